// File: rtl/board_gen.sv
// Flood-It initial-board generator.
// Seeds a 16-bit Fibonacci LFSR on request and streams SIZE*SIZE cell colours in raster order
// as one-cycle write strobes, then holds READY until the request is withdrawn.
// Optional feature macro: NONTRIVIAL_START_EN -- keeps the right and lower neighbours of cell 0
// from sharing its colour, so the first move is never free.
module board_gen #(
    parameter int unsigned MAX_SIZE   = 14,
    parameter int unsigned MAX_COLORS = 8,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              NEW_BOARD,
    input  logic [15:0]       SEED,
    input  logic [4:0]        SIZE,
    input  logic [3:0]        COLOR_NUM,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [2:0]        WR_DATA,
    output logic              BUSY,
    output logic              READY
);

    typedef enum logic [1:0] {StIdle, StSeed, StGen, StDone} state_e;

    localparam logic [15:0] LfsrDefault = 16'hACE1;
    localparam logic [4:0]  MaxSize     = 5'(MAX_SIZE);
    localparam logic [3:0]  MaxColors   = 4'(MAX_COLORS);

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         seed_q, seed_d;
    logic [4:0]          size_q, size_d;
    logic [3:0]          colors_q, colors_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          col_q, col_d;
    logic [2:0]          rej_q, rej_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [2:0]          wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
`ifdef NONTRIVIAL_START_EN
    logic [2:0]          cell0_q, cell0_d;
    logic                neighbour;
    logic [3:0]          cell0_inc;
`endif

    logic [4:0]  size_clamp;
    logic [3:0]  colors_clamp;
    logic [15:0] lfsr_next;
    logic [2:0]  cand;
    logic        accept;
    logic        bound;
    logic [2:0]  bound_val;

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand      = lfsr_next[2:0];

    // Clamp the request configuration into the supported range.
    always_comb begin
        size_clamp   = SIZE;
        colors_clamp = COLOR_NUM;
        if (SIZE < 5'd2) begin
            size_clamp = 5'd2;
        end else if (SIZE > MaxSize) begin
            size_clamp = MaxSize;
        end
        if (COLOR_NUM < 4'd2) begin
            colors_clamp = 4'd2;
        end else if (COLOR_NUM > MaxColors) begin
            colors_clamp = MaxColors;
        end
    end

    // Next-state and registered-output logic for the request/generate handshake.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        seed_d    = seed_q;
        size_d    = size_q;
        colors_d  = colors_q;
        index_d   = index_q;
        row_d     = row_q;
        col_d     = col_q;
        rej_d     = rej_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        accept    = 1'b0;
        bound     = 1'b0;
        bound_val = 3'd0;
`ifdef NONTRIVIAL_START_EN
        cell0_d   = cell0_q;
        neighbour = ((row_q == 5'd0) && (col_q == 5'd1)) || ((row_q == 5'd1) && (col_q == 5'd0));
        cell0_inc = {1'b0, cell0_q} + 4'd1;
`endif

        case (state_q)
            StIdle: begin
                if (NEW_BOARD) begin
                    // Configuration is frozen here; later input changes do not affect this board.
                    seed_d   = SEED;
                    size_d   = size_clamp;
                    colors_d = colors_clamp;
                    state_d  = StSeed;
                end
            end

            StSeed: begin
                if (!NEW_BOARD) begin
                    state_d = StIdle;
                end else begin
                    lfsr_d  = (seed_q == 16'd0) ? LfsrDefault : seed_q;
                    index_d = '0;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    rej_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = StGen;
                end
            end

            StGen: begin
                if (!NEW_BOARD) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (row_q == size_q) begin
                    // Row counter has wrapped past the last row: every cell has been written.
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = StDone;
                end else begin
                    lfsr_d = lfsr_next;
                    accept = ({1'b0, cand} < colors_q);
`ifdef NONTRIVIAL_START_EN
                    if (neighbour && (cand == cell0_q)) begin
                        accept = 1'b0;
                    end
                    if (neighbour && (cell0_inc < colors_q)) begin
                        bound_val = cell0_inc[2:0];
                    end
`endif
                    // Eighth consecutive reject forces a write so generation time stays bounded.
                    bound = !accept && (rej_q == 3'd7);
                    if (accept || bound) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = index_q;
                        wr_data_d = accept ? cand : bound_val;
`ifdef NONTRIVIAL_START_EN
                        if (index_q == '0) begin
                            cell0_d = wr_data_d;
                        end
`endif
                        index_d = index_q + ADDR_W'(1);
                        rej_d   = 3'd0;
                        if (col_q == size_q - 5'd1) begin
                            col_d = 5'd0;
                            row_d = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else begin
                        rej_d = rej_q + 3'd1;
                    end
                end
            end

            StDone: begin
                if (!NEW_BOARD) begin
                    ready_d = 1'b0;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= StIdle;
            lfsr_q    <= LfsrDefault;
            seed_q    <= 16'd0;
            size_q    <= 5'd0;
            colors_q  <= 4'd0;
            index_q   <= '0;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            rej_q     <= 3'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 3'd0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef NONTRIVIAL_START_EN
            cell0_q   <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            size_q    <= size_d;
            colors_q  <= colors_d;
            index_q   <= index_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rej_q     <= rej_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef NONTRIVIAL_START_EN
            cell0_q   <= cell0_d;
`endif
        end
    end

    assign WR_EN   = wr_en_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign BUSY    = busy_q;
    assign READY   = ready_q;

endmodule

// File: tb/tb_board_gen.sv
// Directed testbench for board_gen.
module tb_board_gen;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        NEW_BOARD;
    logic [15:0] SEED;
    logic [4:0]  SIZE;
    logic [3:0]  COLOR_NUM;
    logic        WR_EN;
    logic [7:0]  WR_ADDR;
    logic [2:0]  WR_DATA;
    logic        BUSY;
    logic        READY;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] got_addr[$];
    logic [2:0] got_data[$];
    int         got_cyc[$];
    logic [2:0] exp_data[$];
    int         exp_off[$];

    board_gen dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .NEW_BOARD(NEW_BOARD),
        .SEED     (SEED),
        .SIZE     (SIZE),
        .COLOR_NUM(COLOR_NUM),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .BUSY     (BUSY),
        .READY    (READY)
    );

    always #5 CLOCK = ~CLOCK;

    // cyc equals the number of rising edges seen so far
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Capture every write strobe with the edge number that produced it
    always @(negedge CLOCK) begin
        if (WR_EN === 1'b1) begin
            got_addr.push_back(WR_ADDR);
            got_data.push_back(WR_DATA);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference board: expected colours and the generate-cycle (1-based) of each write
    task automatic model_board(input logic [15:0] seed, input int size, input int colors);
        logic [15:0] l;
        logic [2:0]  c;
        logic [2:0]  v;
        logic [2:0]  cell0;
        int          idx, rej, off;
        bit          acc, wr, nb;
        exp_data.delete();
        exp_off.delete();
        l = (seed == 16'd0) ? 16'hACE1 : seed;
        idx = 0; rej = 0; off = 0; cell0 = 3'd0;
        while (idx < size * size) begin
            off++;
            l   = lfsr_step(l);
            c   = l[2:0];
            acc = (int'(c) < colors);
            nb  = (idx == 1) || (idx == size);
`ifdef NONTRIVIAL_START_EN
            if (nb && c == cell0) acc = 1'b0;
`endif
            wr = 1'b0;
            v  = 3'd0;
            if (acc) begin
                wr = 1'b1;
                v  = c;
            end else begin
                rej++;
                if (rej == 8) begin
                    wr = 1'b1;
`ifdef NONTRIVIAL_START_EN
                    if (nb) v = 3'((int'(cell0) + 1) % colors);
`endif
                end
            end
            if (wr) begin
                if (idx == 0) cell0 = v;
                exp_data.push_back(v);
                exp_off.push_back(off);
                idx++;
                rej = 0;
            end
        end
    endtask

    // Number of captured writes that disagree with the reference (address, data, timing)
    function automatic int board_errs(input int k);
        int e = 0;
        int n;
        if (got_data.size() != exp_data.size()) e++;
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            if (got_addr[i] !== 8'(i)) e++;
            if (got_data[i] !== exp_data[i]) e++;
            if (got_cyc[i] != k + 1 + exp_off[i]) e++;
        end
        return e;
    endfunction

    // Raise the request and wait (bounded) for READY; k is the edge that accepts the request
    task automatic run_board(input logic [15:0] seed, input logic [4:0] size,
                             input logic [3:0] colors, input bit perturb,
                             output int k, output int ready_cyc);
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        SEED      = seed;
        SIZE      = size;
        COLOR_NUM = colors;
        NEW_BOARD = 1'b1;
        k         = cyc + 1;
        ready_cyc = -1;
        for (int i = 0; i < 3000 && ready_cyc < 0; i++) begin
            tick();
            if (perturb && i == 3) begin
                SIZE      = 5'd2;
                COLOR_NUM = 4'd2;
                SEED      = 16'h5555;
            end
            if (READY === 1'b1) ready_cyc = cyc;
        end
        checks++;
        if (ready_cyc < 0) begin
            failures++;
            $display("FAIL ready_timeout seed=%h got READY=%b need READY=1", seed, READY);
        end
    endtask

    task automatic release_board(input string name);
        NEW_BOARD = 1'b0;
        tick();
        checks++;
        if ({READY, BUSY} !== 2'b00) begin
            failures++;
            $display("FAIL %s_release got READY,BUSY=%b need 00", name, {READY, BUSY});
        end
    endtask

    task automatic test_reset();
        int n0;
        bit ready_seen;
        RESET = 1'b1; NEW_BOARD = 1'b0; SEED = 16'd0; SIZE = 5'd0; COLOR_NUM = 4'd0;
        repeat (3) tick();
        checks++;
        if ({WR_EN, WR_ADDR, WR_DATA, BUSY, READY} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state got %b need 0", {WR_EN, WR_ADDR, WR_DATA, BUSY, READY});
        end
        RESET = 1'b0;
        tick();
        SEED = 16'h0001; SIZE = 5'd14; COLOR_NUM = 4'd8; NEW_BOARD = 1'b1;
        repeat (6) tick();
        checks++;
        if ({BUSY, WR_EN} !== 2'b11) begin
            failures++;
            $display("FAIL reset_midgen_busy got BUSY,WR_EN=%b need 11", {BUSY, WR_EN});
        end
        RESET = 1'b1; NEW_BOARD = 1'b0;
        tick();
        checks++;
        if ({WR_EN, WR_ADDR, WR_DATA, BUSY, READY} !== 14'd0) begin
            failures++;
            $display("FAIL reset_midgen got %b need 0", {WR_EN, WR_ADDR, WR_DATA, BUSY, READY});
        end
        repeat (2) tick();
        RESET = 1'b0;
        n0 = got_addr.size();
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (READY !== 1'b0 || BUSY !== 1'b0) ready_seen = 1'b1;
        end
        checks++;
        if (got_addr.size() != n0 || ready_seen) begin
            failures++;
            $display("FAIL reset_quiet got writes=%0d flags=%b need writes=%0d flags=0",
                     got_addr.size() - n0, ready_seen, 0);
        end
    endtask

    task automatic test_basic();
        int k, rc;
        model_board(16'h0001, 2, 8);
        run_board(16'h0001, 5'd2, 4'd8, 1'b0, k, rc);
        checks++;
        if (got_data.size() != 4) begin
            failures++;
            $display("FAIL basic_count got %0d need 4", got_data.size());
        end
        checks++;
        if ({got_data[0], got_data[1], got_data[2], got_data[3]} !== 12'b010_100_000_000) begin
            failures++;
            $display("FAIL basic_data got %0d %0d %0d %0d need 2 4 0 0",
                     got_data[0], got_data[1], got_data[2], got_data[3]);
        end
        checks++;
        if (got_cyc[0] != k + 2) begin
            failures++;
            $display("FAIL basic_first_write got edge %0d need %0d", got_cyc[0], k + 2);
        end
        checks++;
        if (board_errs(k) != 0) begin
            failures++;
            $display("FAIL basic_model got %0d errors need 0", board_errs(k));
        end
        checks++;
        if (rc != k + 6 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready got edge %0d busy %b need edge %0d busy 0", rc, BUSY, k + 6);
        end
        release_board("basic");
    endtask

    task automatic test_reject();
        int k, rc, mg;
        bit bad;
        model_board(16'h0000, 3, 2);
        run_board(16'h0000, 5'd3, 4'd2, 1'b0, k, rc);
        mg = 0; bad = 1'b0;
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] > 3'd1) bad = 1'b1;
            if (i > 0 && got_cyc[i] - got_cyc[i-1] > mg) mg = got_cyc[i] - got_cyc[i-1];
        end
        checks++;
        if (got_data.size() != 9 || bad) begin
            failures++;
            $display("FAIL reject_count got %0d range_err %b need 9 0", got_data.size(), bad);
        end
        // ACE1 steps to 59C3 first; candidate 3 is rejected, so the first write is late
        checks++;
        if (got_cyc[0] <= k + 2) begin
            failures++;
            $display("FAIL reject_first_gap got edge %0d need > %0d", got_cyc[0], k + 2);
        end
        checks++;
        if (mg > 8) begin
            failures++;
            $display("FAIL reject_max_gap got %0d need <= 8", mg);
        end
        checks++;
        if (board_errs(k) != 0) begin
            failures++;
            $display("FAIL reject_model got %0d errors need 0", board_errs(k));
        end
        checks++;
        if (rc != k + 2 + exp_off[8]) begin
            failures++;
            $display("FAIL reject_ready got edge %0d need %0d", rc, k + 2 + exp_off[8]);
        end
        release_board("reject");
    endtask

    task automatic test_clamp();
        int k, rc;
        logic [7:0] maxa;
        bit bad;
        model_board(16'h1234, 14, 8);
        run_board(16'h1234, 5'd31, 4'd15, 1'b1, k, rc);
        maxa = 8'd0; bad = 1'b0;
        for (int i = 0; i < got_addr.size(); i++) begin
            if (got_addr[i] > maxa) maxa = got_addr[i];
            if (got_data[i] > 3'd7) bad = 1'b1;
        end
        checks++;
        if (got_addr.size() != 196 || maxa != 8'd195 || bad) begin
            failures++;
            $display("FAIL clamp_big got writes=%0d max=%0d need 196 195", got_addr.size(), maxa);
        end
        checks++;
        if (board_errs(k) != 0) begin
            failures++;
            $display("FAIL clamp_big_model got %0d errors need 0", board_errs(k));
        end
        release_board("clamp_big");
        model_board(16'h00FF, 2, 2);
        run_board(16'h00FF, 5'd0, 4'd1, 1'b0, k, rc);
        bad = 1'b0;
        for (int i = 0; i < got_data.size(); i++) if (got_data[i] > 3'd1) bad = 1'b1;
        checks++;
        if (got_data.size() != 4 || bad) begin
            failures++;
            $display("FAIL clamp_small got writes=%0d range_err=%b need 4 0", got_data.size(), bad);
        end
        checks++;
        if (board_errs(k) != 0) begin
            failures++;
            $display("FAIL clamp_small_model got %0d errors need 0", board_errs(k));
        end
        release_board("clamp_small");
    endtask

    task automatic test_abort();
        int k, rc;
        bit ready_seen;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        SEED = 16'hBEEF; SIZE = 5'd4; COLOR_NUM = 4'd8; NEW_BOARD = 1'b1;
        for (int i = 0; i < 100 && got_addr.size() < 5; i++) tick();
        NEW_BOARD = 1'b0;
        tick();
        checks++;
        if ({BUSY, READY} !== 2'b00) begin
            failures++;
            $display("FAIL abort_busy got BUSY,READY=%b need 00", {BUSY, READY});
        end
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (READY !== 1'b0) ready_seen = 1'b1;
        end
        checks++;
        if (got_addr.size() != 5 || ready_seen) begin
            failures++;
            $display("FAIL abort_quiet got writes=%0d ready=%b need 5 0", got_addr.size(), ready_seen);
        end
        model_board(16'hBEEF, 4, 8);
        run_board(16'hBEEF, 5'd4, 4'd8, 1'b0, k, rc);
        checks++;
        if (board_errs(k) != 0 || got_addr[0] !== 8'd0) begin
            failures++;
            $display("FAIL abort_restart got %0d errors need 0", board_errs(k));
        end
        release_board("abort");
    endtask

    task automatic test_nontrivial();
        int k, rc, viol, bad;
        viol = 0; bad = 0;
        for (int s = 1; s <= 500; s++) begin
            model_board(16'(s), 5, 8);
            run_board(16'(s), 5'd5, 4'd8, 1'b0, k, rc);
            if (board_errs(k) != 0 || rc != k + 2 + exp_off[24]) bad++;
            if (got_data.size() >= 6 &&
                (got_data[1] == got_data[0] || got_data[5] == got_data[0])) viol++;
            NEW_BOARD = 1'b0;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sweep_model got %0d bad boards need 0", bad);
        end
        checks++;
`ifdef NONTRIVIAL_START_EN
        if (viol != 0) begin
            failures++;
            $display("FAIL sweep_neighbour got %0d violations need 0", viol);
        end
`else
        if (viol == 0) begin
            failures++;
            $display("FAIL sweep_neighbour got 0 violations need > 0");
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_clamp();
        test_abort();
        test_nontrivial();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
